pmem_arbiter: RTL and testbench

PMEM_ARBITER -- requirements
Module: pmem_arbiter

---
 rtl/pmem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_pmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter
// Purpose  : Shares one single-ported physical memory between the instruction
//            fetch unit (IFU) and the load/store unit (LSU). At most one
//            transaction is outstanding: IDLE -> ISSUE -> WAIT -> RESP.
//            Memory returns read data the cycle after mem_valid; that word is
//            captured in WAIT and presented to the owner in RESP until the
//            owner accepts it. Writes also complete through RESP and return
//            the pre-write word.
// Config   : `define PMEM_ARB_RR_EN -> round-robin arbitration between
//            simultaneous requesters (pointer favours IFU after reset).
//            Undefined (default)   -> fixed priority, LSU wins.
// Ports    : clk, rst_n              clock, async active-low reset
//            ifu_req_*/ifu_addr      fetch request (read only)
//            ifu_resp_*/ifu_rdata    fetch response
//            lsu_req_*/lsu_addr/...  load/store request with wen/wdata/wmask
//            lsu_resp_*/lsu_rdata    load/store response
//            mem_*                   physical memory request, mem_rdata in
// Revision : 1.0 - initial release
// ============================================================================
module pmem_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  input  logic          ifu_resp_ready,
  output logic [31:0]   ifu_rdata,

  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [31:0]   lsu_wdata,
  input  logic [7:0]    lsu_wmask,
  output logic          lsu_resp_valid,
  input  logic          lsu_resp_ready,
  output logic [31:0]   lsu_rdata,

  output logic          mem_valid,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [7:0]    mem_wmask,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_owner_lsu;
  logic [AW-1:0]   r_addr;
  logic            r_wen;
  logic [31:0]     r_wdata;
  logic [7:0]      r_wmask;
  logic [31:0]     r_rdata_q;
  logic            r_mem_valid;
  logic            r_ifu_resp_valid;
  logic            r_lsu_resp_valid;

  logic            w_idle;
  logic            w_grant_lsu;
  logic            w_ifu_accept;
  logic            w_lsu_accept;
  logic            w_resp_done;

  // --------------------------------------------------------------------------
  // Arbitration. w_grant_lsu selects the requester offered req_ready; it only
  // matters when at least one side is valid.
  // --------------------------------------------------------------------------
`ifdef PMEM_ARB_RR_EN
  // r_favour_lsu = 1 means IFU was granted last, so LSU wins the next tie.
  logic r_favour_lsu;

  always_comb begin
    w_grant_lsu = lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) begin
      w_grant_lsu = r_favour_lsu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_favour_lsu <= 1'b0;
    end else if (w_ifu_accept) begin
      r_favour_lsu <= 1'b1;
    end else if (w_lsu_accept) begin
      r_favour_lsu <= 1'b0;
    end
  end
`else
  // Fixed priority: LSU always wins a tie, IFU only gets through alone.
  assign w_grant_lsu = lsu_req_valid;
`endif

  assign w_idle = (r_state == ST_IDLE);

  // Ready is gated with rst_n so that every output is 0 while reset is held,
  // even though the reset state itself is IDLE.
  assign w_ifu_accept = rst_n & w_idle & ifu_req_valid & ~w_grant_lsu;
  assign w_lsu_accept = rst_n & w_idle & lsu_req_valid &  w_grant_lsu;

  assign ifu_req_ready = w_ifu_accept;
  assign lsu_req_ready = w_lsu_accept;

  assign w_resp_done = (r_ifu_resp_valid & ifu_resp_ready) |
                       (r_lsu_resp_valid & lsu_resp_ready);

  // --------------------------------------------------------------------------
  // Transaction FSM. The accept edge latches the whole request so the
  // requester may change its inputs immediately afterwards.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_owner_lsu      <= 1'b0;
      r_addr           <= '0;
      r_wen            <= 1'b0;
      r_wdata          <= 32'h0;
      r_wmask          <= 8'h0;
      r_rdata_q        <= 32'h0;
      r_mem_valid      <= 1'b0;
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_lsu_accept) begin
            r_owner_lsu <= 1'b1;
            r_addr      <= lsu_addr;
            r_wen       <= lsu_wen;
            r_wdata     <= lsu_wdata;
            r_wmask     <= lsu_wmask;
            r_mem_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (w_ifu_accept) begin
            r_owner_lsu <= 1'b0;
            r_addr      <= ifu_addr;
            r_wen       <= 1'b0;
            r_wdata     <= 32'h0;
            r_wmask     <= 8'h0;
            r_mem_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // mem_valid was raised on the accept edge; drop it after one cycle.
          r_mem_valid <= 1'b0;
          r_state     <= ST_WAIT;
        end

        ST_WAIT: begin
          // Memory presents its word during this cycle only.
          r_rdata_q        <= mem_rdata;
          r_ifu_resp_valid <= ~r_owner_lsu;
          r_lsu_resp_valid <=  r_owner_lsu;
          r_state          <= ST_RESP;
        end

        ST_RESP: begin
          if (w_resp_done) begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_state          <= ST_IDLE;
          end
        end

        default: begin
          r_mem_valid      <= 1'b0;
          r_ifu_resp_valid <= 1'b0;
          r_lsu_resp_valid <= 1'b0;
          r_state          <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Write strobes are qualified with mem_valid so a stale latched
  // write can never be seen outside the ISSUE cycle.
  // --------------------------------------------------------------------------
  assign mem_valid      = r_mem_valid;
  assign mem_raddr      = r_addr;
  assign mem_waddr      = r_addr;
  assign mem_wen        = r_mem_valid & r_wen;
  assign mem_wdata      = r_wdata;
  assign mem_wmask      = r_mem_valid ? r_wmask : 8'h0;

  assign ifu_resp_valid = r_ifu_resp_valid;
  assign lsu_resp_valid = r_lsu_resp_valid;
  assign ifu_rdata      = r_rdata_q;
  assign lsu_rdata      = r_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_arbiter
// Purpose  : Directed self-checking bench for pmem_arbiter. A small memory
//            model returns tb_word in the cycle after mem_valid and 0
//            otherwise. Expected arbitration order follows PMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = 32'h0;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready = 1'b0;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr = 32'h0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [7:0]  lsu_wmask = 8'h0;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready = 1'b0;
  logic [31:0] lsu_rdata;
  logic        mem_valid;
  logic [31:0] mem_raddr;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_word = 32'h0;
  logic        saw_valid = 1'b0;

  pmem_arbiter #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_valid(mem_valid), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word is visible for the whole cycle following mem_valid.
  always @(negedge clk) begin
    mem_rdata = saw_valid ? tb_word : 32'h0;
    saw_valid = mem_valid;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    tick();
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ifu_ready got %b exp 0", ifu_req_ready); end
    checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready got %b exp 0", lsu_req_ready); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b exp 0", mem_valid); end
    checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b exp 00", {ifu_resp_valid, lsu_resp_valid}); end
    checks++; if (ifu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", ifu_rdata); end
    checks++; if (mem_raddr !== 32'h0) begin errors++; $display("FAIL rst_mem_raddr got %h exp 0", mem_raddr); end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ifu_read;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    tb_word       = 32'h0000_0413;
    #1;
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL ifu_ready got %b exp 1", ifu_req_ready); end
    checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL ifu_lsu_ready got %b exp 0", lsu_req_ready); end
    tick();
    ifu_req_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL ifu_mem_valid got %b exp 1", mem_valid); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL ifu_mem_wen got %b exp 0", mem_wen); end
    checks++; if (mem_raddr !== 32'h8000_0000) begin errors++; $display("FAIL ifu_mem_raddr got %h exp 80000000", mem_raddr); end
    checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL ifu_ready_issue got %b exp 0", ifu_req_ready); end
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL ifu_mem_valid_wait got %b exp 0", mem_valid); end
    checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_resp_early got %b exp 0", ifu_resp_valid); end
    tick();
    checks++; if (ifu_resp_valid !== 1'b1) begin errors++; $display("FAIL ifu_resp_valid got %b exp 1", ifu_resp_valid); end
    checks++; if (ifu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL ifu_rdata got %h exp 00000413", ifu_rdata); end
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_nonowner_resp got %b exp 0", lsu_resp_valid); end
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
    checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_resp_clear got %b exp 0", ifu_resp_valid); end
  endtask

  task automatic test_lsu_write;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 8'h0F;
    tb_word       = 32'hCAFE_F00D;
    #1;
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", lsu_req_ready); end
    tick();
    lsu_req_valid = 1'b0;
    lsu_wen       = 1'b0;
    checks++; if ({mem_valid, mem_wen} !== 2'b11) begin errors++; $display("FAIL wr_mem_valid_wen got %b exp 11", {mem_valid, mem_wen}); end
    checks++; if (mem_waddr !== 32'h8000_1000) begin errors++; $display("FAIL wr_waddr got %h exp 80001000", mem_waddr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata got %h exp deadbeef", mem_wdata); end
    checks++; if (mem_wmask !== 8'h0F) begin errors++; $display("FAIL wr_wmask got %h exp 0f", mem_wmask); end
    tick();
    checks++; if ({mem_valid, mem_wen} !== 2'b00) begin errors++; $display("FAIL wr_one_cycle got %b exp 00", {mem_valid, mem_wen}); end
    tick();
    checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("FAIL wr_resp_valid got %b exp 1", lsu_resp_valid); end
    checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL wr_nonowner_resp got %b exp 0", ifu_resp_valid); end
    checks++; if (lsu_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_prewrite_rdata got %h exp cafef00d", lsu_rdata); end
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
  endtask

  task automatic test_arbitration;
    logic exp_lsu;
    ifu_addr       = 32'h0000_0100;
    lsu_addr       = 32'h0000_0200;
    lsu_wen        = 1'b0;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    ifu_req_valid  = 1'b1;
    lsu_req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef PMEM_ARB_RR_EN
      exp_lsu = (i % 2) == 1;
`else
      exp_lsu = 1'b1;
`endif
      tb_word = 32'h0000_00A0 + i;
      if (i == 3) begin
        // Drop both right after the last accept edge.
        #1;
      end else begin
        #1;
      end
      checks++; if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, ~exp_lsu}) begin errors++; $display("FAIL arb_grant[%0d] got %b exp %b", i, {lsu_req_ready, ifu_req_ready}, {exp_lsu, ~exp_lsu}); end
      tick();
      if (i == 3) begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
      end
      checks++; if (mem_raddr !== (exp_lsu ? 32'h200 : 32'h100)) begin errors++; $display("FAIL arb_addr[%0d] got %h exp %h", i, mem_raddr, exp_lsu ? 32'h200 : 32'h100); end
      tick();
      tick();
      checks++; if ({lsu_resp_valid, ifu_resp_valid} !== {exp_lsu, ~exp_lsu}) begin errors++; $display("FAIL arb_resp[%0d] got %b exp %b", i, {lsu_resp_valid, ifu_resp_valid}, {exp_lsu, ~exp_lsu}); end
      checks++; if ((exp_lsu ? lsu_rdata : ifu_rdata) !== 32'h0000_00A0 + i) begin errors++; $display("FAIL arb_rdata[%0d] got %h exp %h", i, exp_lsu ? lsu_rdata : ifu_rdata, 32'h0000_00A0 + i); end
      tick();
    end
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b0;
  endtask

  task automatic test_stall;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0040;
    tb_word       = 32'h1357_9BDF;
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2000;
    lsu_wen       = 1'b0;
    #1;
    checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_issue got %b exp 0", lsu_req_ready); end
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (ifu_resp_valid !== 1'b1) begin errors++; $display("FAIL stall_resp_valid[%0d] got %b exp 1", c, ifu_resp_valid); end
      checks++; if (ifu_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL stall_rdata[%0d] got %h exp 13579bdf", c, ifu_rdata); end
      checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL stall_lsu_ready[%0d] got %b exp 0", c, lsu_req_ready); end
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL stall_mem_valid[%0d] got %b exp 0", c, mem_valid); end
      tick();
    end
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
    tb_word        = 32'h2468_ACE0;
    #1;
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL stall_lsu_accept got %b exp 1", lsu_req_ready); end
    checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL stall_ifu_clear got %b exp 0", ifu_resp_valid); end
    tick();
    lsu_req_valid = 1'b0;
    checks++; if ({mem_valid, mem_raddr} !== {1'b1, 32'h8000_2000}) begin errors++; $display("FAIL stall_lsu_issue got %b/%h exp 1/80002000", mem_valid, mem_raddr); end
    tick();
    tick();
    checks++; if ({lsu_resp_valid, lsu_rdata} !== {1'b1, 32'h2468_ACE0}) begin errors++; $display("FAIL stall_lsu_resp got %b/%h exp 1/2468ace0", lsu_resp_valid, lsu_rdata); end
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
  endtask

  task automatic test_drop;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0300;
    #1;
    ifu_req_valid = 1'b0;
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL drop_mem_valid got %b exp 0", mem_valid); end
    tick();
    checks++; if ({mem_valid, ifu_resp_valid} !== 2'b00) begin errors++; $display("FAIL drop_no_txn got %b exp 00", {mem_valid, ifu_resp_valid}); end
  endtask

  task automatic test_reset_mid;
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0080;
    tb_word        = 32'hBADC_0FFE;
    ifu_resp_ready = 1'b1;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 5'b0) begin errors++; $display("FAIL rmid_ctrl got %b exp 00000", {mem_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}); end
    checks++; if ({ifu_rdata, mem_raddr} !== 64'h0) begin errors++; $display("FAIL rmid_data got %h/%h exp 0/0", ifu_rdata, mem_raddr); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({ifu_resp_valid, mem_valid} !== 2'b00) begin errors++; $display("FAIL rmid_no_resp[%0d] got %b exp 00", c, {ifu_resp_valid, mem_valid}); end
    end
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    tb_word       = 32'h0BAD_F00D;
    #1;
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 1'b0;
    checks++; if ({mem_valid, mem_raddr} !== {1'b1, 32'h8000_0100}) begin errors++; $display("FAIL rmid_issue got %b/%h exp 1/80000100", mem_valid, mem_raddr); end
    tick();
    tick();
    checks++; if ({ifu_resp_valid, ifu_rdata} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL rmid_resp got %b/%h exp 1/0badf00d", ifu_resp_valid, ifu_rdata); end
    tick();
    ifu_resp_ready = 1'b0;
    checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", ifu_resp_valid); end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_arbitration();
    test_stall();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
